// File: rtl/eprisc_intc_pkg.sv
// Shared constants for the epRISC interrupt controller: register map,
// VEC register layout and the lowest-index priority helper.
package eprisc_intc_pkg;

  typedef enum logic [1:0] {
    REG_PEND = 2'd0,
    REG_MASK = 2'd1,
    REG_VEC  = 2'd2,
    REG_NMI  = 2'd3
  } reg_sel_e;

  localparam int VEC_VALID_BIT = 31;
  localparam int MAX_IRQ       = 16;

  // Lowest set index wins; scanning downward lets the last hit be the lowest.
  function automatic logic [3:0] lowest_idx(input logic [MAX_IRQ-1:0] req);
    lowest_idx = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--)
      if (req[i]) lowest_idx = 4'(i);
  endfunction

endpackage

// File: rtl/eprisc_int_controller_if.sv
// Register-select side of the controller's bus port; the shared tri-state
// data bus stays a plain inout on the top level.
interface eprisc_int_controller_if;
  logic [1:0] iAddr;
  logic       iWrite;
  logic       iEnable;

  modport master (output iAddr, output iWrite, output iEnable);
  modport slave  (input  iAddr, input  iWrite, input  iEnable);
endinterface

// File: rtl/eprisc_intc_edge.sv
// One request line: optional two-flop synchroniser (EPRISC_INTC_SYNC_EN)
// followed by a rising-edge detector whose history resets to one.
module eprisc_intc_edge (
  input  logic iClk,
  input  logic iRst,
  input  logic iLine,
  output logic oRise
);
  logic line_s;
  logic prev_q, prev_d;

`ifdef EPRISC_INTC_SYNC_EN
  logic [1:0] sync_q, sync_d;

  assign sync_d = {sync_q[0], iLine};

  always_ff @(posedge iClk or negedge iRst)
    if (!iRst) sync_q <= '1;
    else       sync_q <= sync_d;

  assign line_s = sync_q[1];
`else
  assign line_s = iLine;
`endif

  assign prev_d = line_s;

  // Resetting history high keeps a line held through reset from requesting.
  always_ff @(posedge iClk or negedge iRst)
    if (!iRst) prev_q <= 1'b1;
    else       prev_q <= prev_d;

  assign oRise = line_s & ~prev_q;
endmodule

// File: rtl/eprisc_int_controller.sv
// epRISC interrupt controller top: pending/mask/NMI registers, priority
// vector with read-acknowledge, and the shared data bus. Optional
// input synchroniser: EPRISC_INTC_SYNC_EN.
module eprisc_int_controller
  import eprisc_intc_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic                     iClk,
  input  logic                     iRst,
  eprisc_int_controller_if.slave   bus,
  inout  wire  [31:0]              bData,
  input  logic [NUM_IRQ-1:0]       iIrq,
  input  logic                     iNMI,
  output logic                     oInt,
  output logic                     oNMInt
);
  logic [NUM_IRQ:0]   rise;
  logic [NUM_IRQ-1:0] pend_q, pend_d, mask_q, mask_d;
  logic [NUM_IRQ-1:0] pm, ack_oh;
  logic               nmi_q, nmi_d, int_q, int_d, nmi_out_q, nmi_out_d;
  logic [31:0]        rdata_out_q, rdata_out_d, vec_word;
  logic [3:0]         vec_idx;
  logic               rd_en, wr_en, unused_wdata;
  reg_sel_e           sel;

  eprisc_intc_edge u_edge [NUM_IRQ:0] (
    .iClk  (iClk),
    .iRst  (iRst),
    .iLine ({iNMI, iIrq}),
    .oRise (rise)
  );

  assign rd_en        = bus.iEnable && !bus.iWrite;
  assign wr_en        = bus.iEnable && bus.iWrite;
  assign sel          = reg_sel_e'(bus.iAddr);
  assign unused_wdata = ^bData;

  assign pm      = pend_q & mask_q;
  assign ack_oh  = pm & (~pm + NUM_IRQ'(1));
  assign vec_idx = lowest_idx(MAX_IRQ'(pm));

  always_comb begin
    vec_word = '0;
    if (|pm) begin
      vec_word[VEC_VALID_BIT] = 1'b1;
      vec_word[3:0]           = vec_idx;
    end
  end

  always_comb begin
    pend_d      = pend_q;
    mask_d      = mask_q;
    nmi_d       = nmi_q;
    rdata_out_d = rdata_out_q;
    if (wr_en) begin
      case (sel)
        REG_PEND: pend_d = pend_q & ~bData[NUM_IRQ-1:0];
        REG_MASK: mask_d = bData[NUM_IRQ-1:0];
        REG_NMI:  if (bData[0]) nmi_d = 1'b0;
        default:  ;
      endcase
    end
    if (rd_en) begin
      case (sel)
        REG_PEND: rdata_out_d = 32'(pend_q);
        REG_MASK: rdata_out_d = 32'(mask_q);
        REG_VEC: begin
          rdata_out_d = vec_word;
          pend_d      = pend_q & ~ack_oh;
        end
        default:  rdata_out_d = {31'b0, nmi_q};
      endcase
    end
    // New edges are applied last so they win over a same-cycle clear.
    pend_d    = pend_d | rise[NUM_IRQ-1:0];
    if (rise[NUM_IRQ]) nmi_d = 1'b1;
    int_d     = |pm;
    nmi_out_d = nmi_q;
  end

  always_ff @(posedge iClk or negedge iRst)
    if (!iRst) begin
      pend_q      <= '0;
      mask_q      <= '0;
      nmi_q       <= 1'b0;
      rdata_out_q <= '0;
      int_q       <= 1'b0;
      nmi_out_q   <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      nmi_q       <= nmi_d;
      rdata_out_q <= rdata_out_d;
      int_q       <= int_d;
      nmi_out_q   <= nmi_out_d;
    end

  assign bData  = rd_en ? rdata_out_q : 'z;
  assign oInt   = int_q;
  assign oNMInt = nmi_out_q;
endmodule
